// File: rtl/dm_write_arbiter.sv
// Shared data-memory write arbiter.
// Each core posts writes into a one-entry buffer. Buffers drain into the
// single-port data memory one write per cycle, in round-robin order.
// Optional feature macro: DMWA_COALESCE_EN. When it is defined, a rewrite to
// the same address in a held buffer replaces the buffered data and does not
// flag overflow.
module dm_write_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [NUM_CORES-1:0]          core_hold,
  output logic [NUM_CORES-1:0]          overflow,
  output logic                          drained,
  output logic [15:0]                   commit_cnt
);

  localparam int LW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] w_valid;
  logic [NUM_CORES-1:0] w_ovf;
  logic [NUM_CORES-1:0] w_gnt_oh;
  logic [ADDR_W-1:0]    w_addr [NUM_CORES];
  logic [DATA_W-1:0]    w_data [NUM_CORES];
  logic                 w_gnt_vld;
  logic [LW-1:0]        w_gnt_idx;
  int unsigned          w_scan;

  logic [LW-1:0]        r_last;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [15:0]          r_cnt;

  // Round-robin grant: first valid buffer after the last granted one.
  always_comb begin
    w_gnt_oh  = '0;
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    w_scan    = 0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      w_scan = 32'(r_last) + k;
      if (w_scan >= NUM_CORES) w_scan = w_scan - NUM_CORES;
      if (!w_gnt_vld && w_valid[w_scan[LW-1:0]]) begin
        w_gnt_vld                    = 1'b1;
        w_gnt_idx                    = w_scan[LW-1:0];
        w_gnt_oh[w_scan[LW-1:0]]     = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic              r_v;
    logic              r_o;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [ADDR_W-1:0] w_in_addr;
    logic [DATA_W-1:0] w_in_data;
    logic              w_busy;
    logic              w_take;
    logic              w_merge;
    logic              w_lost;

    assign w_in_addr = core_addr[gi*ADDR_W +: ADDR_W];
    assign w_in_data = core_wdata[gi*DATA_W +: DATA_W];
    // A write collides only with an occupied buffer that is not draining now.
    assign w_busy    = core_we[gi] & r_v & ~w_gnt_oh[gi];
    assign w_take    = core_we[gi] & ~w_busy;
`ifdef DMWA_COALESCE_EN
    assign w_merge   = w_busy & (w_in_addr == r_a);
`else
    assign w_merge   = 1'b0;
`endif
    assign w_lost    = w_busy & ~w_merge;

    // Posted-write buffer: capture, drain on grant, merge or flag collisions.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_o <= 1'b0;
        r_a <= '0;
        r_d <= '0;
      end else begin
        if (w_take) begin
          r_v <= 1'b1;
          r_a <= w_in_addr;
          r_d <= w_in_data;
        end else if (w_gnt_oh[gi]) begin
          r_v <= 1'b0;
        end
        if (w_merge) r_d <= w_in_data;
        if (w_lost)  r_o <= 1'b1;
      end
    end

    assign w_valid[gi] = r_v;
    assign w_ovf[gi]   = r_o;
    assign w_addr[gi]  = r_a;
    assign w_data[gi]  = r_d;
  end

  // Memory port, round-robin pointer and commit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_last      <= LW'(NUM_CORES - 1);
      r_cnt       <= '0;
    end else if (w_gnt_vld) begin
      r_mem_we    <= 1'b1;
      r_mem_addr  <= w_addr[w_gnt_idx];
      r_mem_wdata <= w_data[w_gnt_idx];
      r_last      <= w_gnt_idx;
      r_cnt       <= r_cnt + 16'd1;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_hold  = w_valid;
  assign overflow   = w_ovf;
  assign drained    = ~|w_valid & ~r_mem_we;
  assign commit_cnt = r_cnt;

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Bench for dm_write_arbiter: fixed vectors, hand sequences, random traffic
// against a reference model, and commit counter wrap.
module tb_dm_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      core_we = '0;
  logic [N*AW-1:0]   core_addr = '0;
  logic [N*DW-1:0]   core_wdata = '0;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [N-1:0]      core_hold;
  logic [N-1:0]      overflow;
  logic              drained;
  logic [15:0]       commit_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dm_write_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .overflow(overflow),
    .drained(drained), .commit_cnt(commit_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit          mv [N];
  logic [15:0] ma [N];
  logic [15:0] md [N];
  int          mlast;
  bit          m_we;
  logic [15:0] m_addr, m_data, m_cnt;
  logic [N-1:0] m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mv[i] = 0; ma[i] = 0; md[i] = 0; end
    mlast = N - 1; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_ovf = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] we, input logic [N*AW-1:0] a,
                            input logic [N*DW-1:0] d);
    int g = -1;
    bit nv [N];
    for (int k = 1; k <= N; k++) begin
      int idx = (mlast + k) % N;
      if (g < 0 && mv[idx]) g = idx;
    end
    nv = mv;
    if (g >= 0) begin
      m_we = 1; m_addr = ma[g]; m_data = md[g]; nv[g] = 0; mlast = g; m_cnt = m_cnt + 1;
    end else begin
      m_we = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (we[i]) begin
        if (!mv[i] || i == g) begin
          nv[i] = 1; ma[i] = a[i*AW +: AW]; md[i] = d[i*DW +: DW];
        end
`ifdef DMWA_COALESCE_EN
        else if (a[i*AW +: AW] == ma[i]) md[i] = d[i*DW +: DW];
`endif
        else m_ovf[i] = 1'b1;
      end
    end
    mv = nv;
  endtask

  function automatic logic [N-1:0] m_hold();
    logic [N-1:0] h;
    for (int i = 0; i < N; i++) h[i] = mv[i];
    return h;
  endfunction

  task automatic compare_model();
    check("model.mem_we", mem_we, m_we);
    check("model.mem_addr", mem_addr, m_addr);
    check("model.mem_wdata", mem_wdata, m_data);
    check("model.core_hold", core_hold, m_hold());
    check("model.overflow", overflow, m_ovf);
    check("model.drained", drained, (m_hold() == '0) && !m_we);
    check("model.commit_cnt", commit_cnt, m_cnt);
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input logic [N-1:0] we, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d);
    core_we = we; core_addr = a; core_wdata = d;
    model_edge(we, a, d);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_we = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.core_hold", core_hold, 0);
    check("rst.overflow", overflow, 0);
    check("rst.drained", drained, 1);
    check("rst.commit_cnt", commit_cnt, 0);
  endtask

  function automatic logic [63:0] pk(input logic [15:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit           rst;
    logic [N-1:0] we;
    logic [63:0]  a;
    logic [63:0]  d;
    bit           x_we;
    logic [15:0]  x_addr;
    logic [15:0]  x_data;
    logic [N-1:0] x_hold;
    logic [N-1:0] x_ovf;
    bit           x_drn;
    logic [15:0]  x_cnt;
  } vec_t;

  function automatic vec_t mk(input bit r, input logic [N-1:0] we,
                              input logic [63:0] a, input logic [63:0] d,
                              input bit xwe, input logic [15:0] xa, input logic [15:0] xd,
                              input logic [N-1:0] xh, input logic [N-1:0] xo,
                              input bit xdr, input logic [15:0] xc);
    vec_t v;
    v.rst = r; v.we = we; v.a = a; v.d = d; v.x_we = xwe; v.x_addr = xa;
    v.x_data = xd; v.x_hold = xh; v.x_ovf = xo; v.x_drn = xdr; v.x_cnt = xc;
    return v;
  endfunction

  vec_t tbl[$];
  logic [15:0]  ov_addr, ov_data, ov_commit;
  logic [N-1:0] ov_flag;
  logic [63:0]  z;

  initial begin
    z = '0;
`ifdef DMWA_COALESCE_EN
    ov_addr = 16'h0020; ov_data = 16'h5555; ov_commit = 16'h5555; ov_flag = 4'b0000;
`else
    ov_addr = 16'h0021; ov_data = 16'h2222; ov_commit = 16'h1111; ov_flag = 4'b0100;
`endif
    // single write
    tbl.push_back(mk(1, 4'b0001, pk(16'h0010, 0, 0, 0), pk(16'hBEEF, 0, 0, 0), 0, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h0010, 16'hBEEF, 4'b0000, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, z, z, 0, 16'h0010, 16'hBEEF, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 4'b0000, z, z, 0, 16'h0010, 16'hBEEF, 4'b0000, 4'b0000, 1, 1));
    // simultaneous writes
    tbl.push_back(mk(1, 4'b1111, pk(16'h0100, 16'h0101, 16'h0102, 16'h0103),
                     pk(16'hD000, 16'hD001, 16'hD002, 16'hD003), 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h0100, 16'hD000, 4'b1110, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h0101, 16'hD001, 4'b1100, 4'b0000, 0, 2));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h0102, 16'hD002, 4'b1000, 4'b0000, 0, 3));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h0103, 16'hD003, 4'b0000, 4'b0000, 0, 4));
    tbl.push_back(mk(0, 4'b0000, z, z, 0, 16'h0103, 16'hD003, 4'b0000, 4'b0000, 1, 4));
    // round-robin fairness, each core rewriting on its grant edge
    tbl.push_back(mk(1, 4'b0110, pk(0, 16'h11, 16'h12, 0), pk(0, 16'h1001, 16'h2001, 0), 0, 0, 0, 4'b0110, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0010, pk(0, 16'h11, 0, 0), pk(0, 16'h1002, 0, 0), 1, 16'h11, 16'h1001, 4'b0110, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0100, pk(0, 0, 16'h12, 0), pk(0, 0, 16'h2002, 0), 1, 16'h12, 16'h2001, 4'b0110, 4'b0000, 0, 2));
    tbl.push_back(mk(0, 4'b0010, pk(0, 16'h11, 0, 0), pk(0, 16'h1003, 0, 0), 1, 16'h11, 16'h1002, 4'b0110, 4'b0000, 0, 3));
    tbl.push_back(mk(0, 4'b0100, pk(0, 0, 16'h12, 0), pk(0, 0, 16'h2003, 0), 1, 16'h12, 16'h2002, 4'b0110, 4'b0000, 0, 4));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h11, 16'h1003, 4'b0100, 4'b0000, 0, 5));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h12, 16'h2003, 4'b0000, 4'b0000, 0, 6));
    tbl.push_back(mk(0, 4'b0000, z, z, 0, 16'h12, 16'h2003, 4'b0000, 4'b0000, 1, 6));
    // collision on held buffer 2 while core 0 is granted
    tbl.push_back(mk(1, 4'b0101, pk(16'h30, 0, 16'h20, 0), pk(16'hA0A0, 0, 16'h1111, 0), 0, 0, 0, 4'b0101, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0100, pk(0, 0, ov_addr, 0), pk(0, 0, ov_data, 0), 1, 16'h30, 16'hA0A0, 4'b0100, ov_flag, 0, 1));
    tbl.push_back(mk(0, 4'b0000, z, z, 1, 16'h20, ov_commit, 4'b0000, ov_flag, 0, 2));
    tbl.push_back(mk(0, 4'b0000, z, z, 0, 16'h20, ov_commit, 4'b0000, ov_flag, 1, 2));

    foreach (tbl[r]) begin
      if (tbl[r].rst) do_reset();
      step(tbl[r].we, tbl[r].a, tbl[r].d);
      check($sformatf("tbl[%0d].mem_we", r), mem_we, tbl[r].x_we);
      check($sformatf("tbl[%0d].mem_addr", r), mem_addr, tbl[r].x_addr);
      check($sformatf("tbl[%0d].mem_wdata", r), mem_wdata, tbl[r].x_data);
      check($sformatf("tbl[%0d].core_hold", r), core_hold, tbl[r].x_hold);
      check($sformatf("tbl[%0d].overflow", r), overflow, tbl[r].x_ovf);
      check($sformatf("tbl[%0d].drained", r), drained, tbl[r].x_drn);
      check($sformatf("tbl[%0d].commit_cnt", r), commit_cnt, tbl[r].x_cnt);
    end

    // reset while draining: three buffers valid, mem_we high
    do_reset();
    step(4'b1111, pk(16'h200, 16'h201, 16'h202, 16'h203), pk(16'h1, 16'h2, 16'h3, 16'h4));
    step(4'b0000, z, z);
    check("mid.pre_we", mem_we, 1);
    check("mid.pre_hold", core_hold, 4'b1110);
    core_we = '0;
    rst = 1'b1;
    #1;
    check("mid.mem_we", mem_we, 0);
    check("mid.hold", core_hold, 0);
    check("mid.drained", drained, 1);
    check("mid.cnt", commit_cnt, 0);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b1001, pk(16'h300, 0, 0, 16'h303), pk(16'hAAAA, 0, 0, 16'hBBBB));
    step(4'b0000, z, z);
    check("mid.first_gnt_we", mem_we, 1);
    check("mid.first_gnt_addr", mem_addr, 16'h300);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [N-1:0]    we;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        we = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
        for (int i = 0; i < N; i++) begin
          a[i*AW +: AW] = 16'h40 + 16'($urandom_range(0, 3));
          d[i*DW +: DW] = 16'($urandom);
        end
        step(we, a, d);
      end
    end

    // commit counter wrap: cores 1 and 2 alternate for 65536 commits
    do_reset();
    step(4'b0110, pk(0, 16'h11, 16'h12, 0), pk(0, 16'h7000, 16'h8000, 0));
    for (int n = 0; n < 65536; n++) begin
      step((n % 2 == 0) ? 4'b0010 : 4'b0100, pk(0, 16'h11, 16'h12, 0),
           pk(0, 16'($urandom), 16'($urandom), 0));
    end
    check("wrap.cnt", commit_cnt, 16'h0000);
    check("wrap.mem_we", mem_we, 1);
    check("wrap.ovf", overflow, 0);
    step(4'b0000, z, z);
    check("wrap.g1_addr", mem_addr, 16'h11);
    check("wrap.g1_cnt", commit_cnt, 16'h0001);
    step(4'b0000, z, z);
    check("wrap.g2_addr", mem_addr, 16'h12);
    step(4'b0000, z, z);
    check("wrap.drained", drained, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_write_arbiter.md
# dm_write_arbiter

Shared data-memory write arbiter sitting directly downstream of the processor cores. Each core's data-memory write (address from AR, data from the bus, write enable) lands in a one-entry per-core posted-write buffer. Buffers drain into the single-port shared data memory one write per cycle, in round-robin order. The arbiter raises a per-core hold that the core controller folds into that core's `status` stall. It also reports when all posted writes have committed, so `end_process` can be qualified.

## Interface
Parameters:
- `NUM_CORES`, 4, number of cores served (2..8)
- `ADDR_W`, 16, data-memory address width
- `DATA_W`, 16, data width

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `core_we` in NUM_CORES: per-core `DM_write_en`.
- `core_addr` in NUM_CORES*ADDR_W: per-core `AR_out`, core i at bits [i*ADDR_W +: ADDR_W].
- `core_wdata` in NUM_CORES*DATA_W: per-core `bus`, same packing as `core_addr`.
- `mem_we` out 1: shared DM write enable (registered).
- `mem_addr` out ADDR_W: shared DM address (registered).
- `mem_wdata` out DATA_W: shared DM write data (registered).
- `core_hold` out NUM_CORES: core i's buffer is occupied.
- `overflow` out NUM_CORES: sticky flag; a write to core i was lost.
- `drained` out 1: no buffer valid and `mem_we` low.
- `commit_cnt` out 16: count of committed writes; wraps.

## Operation
- State per core i: `valid[i]`, `addr[i]`, `data[i]`. Global state: round-robin pointer `last` (log2 NUM_CORES bits), output registers, `commit_cnt`, `overflow`.
- **Grant.** Each cycle, grant g is the first valid index found scanning `last+1, last+2, …` modulo NUM_CORES. There is no grant when no buffer is valid.
- **On a grant at the edge:**
  - `mem_we` is set to 1.
  - `mem_addr`/`mem_wdata` load from buffer g.
  - `valid[g]` is cleared.
  - `last` is set to g.
  - `commit_cnt` increments.
- **No grant:** `mem_we` goes to 0. `mem_addr`/`mem_wdata` hold their values.
- **Capture.** `core_we[i]` is accepted at the edge when `valid[i]`=0 or i==g. On acceptance, `valid[i]` is set to 1 and addr/data are loaded.
  - For i==g, the granted entry commits and the new write takes the buffer in the same edge.
- **Lost write.** `core_we[i]` with `valid[i]`=1 and i≠g is dropped, and `overflow[i]` is set (see Configuration for the alternative). `overflow` clears only on `rst`.
- **Hold.** `core_hold[i]` = `valid[i]`, combinational from the register. The controller must stall core i while it is high.
- **Drained.** `drained` = ~|valid & ~mem_we.
- **Reset values:** valid=0, `last`=NUM_CORES-1 (so core 0 has first priority), `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `commit_cnt`=0, `overflow`=0, `core_hold`=0, `drained`=1.
- **Reset mid-operation:** all buffered, uncommitted writes are discarded. A `mem_we` already presented is deasserted asynchronously.

## Timing
- A write captured at edge k is granted at edge k+1 at the earliest. `mem_we` is high during cycle k+1→k+2, and the memory commits at edge k+2.
- Worst-case wait from capture to grant is NUM_CORES-1 cycles after the buffer becomes eligible.
- Throughput is one committed write per cycle when any buffer is valid.
- `core_hold[i]` rises the cycle after capture and falls the cycle after its grant edge.
- Posted writes are not visible to DM reads until their commit edge. Software and the controller accept this ordering.

## Configuration
- Macro: `DMWA_COALESCE_EN`.
- **Defined:** `core_we[i]` with `valid[i]`=1, i≠g, and `core_addr[i]`==`addr[i]` overwrites `data[i]`. `overflow[i]` is not set. A differing address still sets overflow and drops the write.
- **Undefined:** every write to an occupied, non-granted buffer is dropped and sets `overflow[i]`.

## Test plan
- **Reset, then single write.** Core 0 writes addr 0x0010, data 0xBEEF at edge 1.
  - Required: `mem_we`=1 with 0x0010/0xBEEF in cycle 2→3 only.
  - Required: `commit_cnt`=1, `drained`=1 from cycle 3.
- **Simultaneous writes.** All 4 cores write one cycle, addresses 0x100+i.
  - Required: commits in order 0,1,2,3 on four consecutive cycles.
  - Required: `core_hold[3]` high for 4 cycles.
- **Round-robin fairness.** Cores 1 and 2 write continuously, each rewriting on its grant cycle.
  - Required: grants alternate 1,2,1,2.
  - Required: no overflow; `commit_cnt` increments every cycle.
- **Overflow.** Core 2 writes 0x20 and then, while held, writes 0x21 while core 0 is granted.
  - Without the macro: `overflow[2]`=1 and only 0x20 commits.
  - With `DMWA_COALESCE_EN`, same-address rewrite with data 0x5555: the committed data is 0x5555 and `overflow[2]`=0.
- **Reset mid-drain.** Assert `rst` with 3 buffers valid and `mem_we`=1.
  - Required: `mem_we` goes to 0 immediately, and `drained`=1 with `commit_cnt`=0 after release.
  - Required: the first post-reset grant goes to core 0.
- **Counter wrap.** Commit 65536 writes.
  - Required: `commit_cnt` returns to 0x0000 with no side effect on grants.
